// File: rtl/sdr_read_path_pkg.sv
// Shared SDRAM read-path definitions: default sizes, latency helper and the
// event record that travels through the CAS-latency delay pipe.
package sdr_read_path_pkg;

  localparam int SDR_DSIZE     = 32;
  localparam int SDR_CAS_LAT   = 3;
  localparam int SDR_BURST_LEN = 8;
  localparam int SDR_IN_REG    = 1;

  // Legal CAS latency encodings (mode-register values)
  typedef enum logic [2:0] {
    CAS_LAT_2 = 3'd2,
    CAS_LAT_3 = 3'd3
  } cas_lat_e;

  // Legal burst length encodings (mode-register BL field)
  typedef enum logic [2:0] {
    BL_1 = 3'd0,
    BL_2 = 3'd1,
    BL_4 = 3'd2,
    BL_8 = 3'd3
  } burst_len_e;

  // One slot of the delay pipe: a READ start and/or a BURST TERMINATE stop
  typedef struct packed {
    logic start;
    logic stop;
  } rd_evt_t;

  // Clocks from READ command to first word on DATAOUT
  function automatic int rd_latency(input int cas_lat, input int in_reg);
    return cas_lat + in_reg;
  endfunction

  // True when the (CAS latency, burst length, input register) triple is supported
  function automatic logic legal_cfg(input int cas_lat, input int burst_len, input int in_reg);
    logic ok_cas;
    logic ok_bl;
    logic ok_reg;
    ok_cas = (cas_lat == 2) || (cas_lat == 3);
    ok_bl  = (burst_len == 1) || (burst_len == 2) || (burst_len == 4) || (burst_len == 8);
    ok_reg = (in_reg == 0) || (in_reg == 1);
    return ok_cas && ok_bl && ok_reg;
  endfunction

endpackage

// File: rtl/sdr_read_path_if.sv
// Command/data bundle between the SDRAM command path and the read data path.
interface sdr_read_path_if
  import sdr_read_path_pkg::*;
#(
  parameter int DSIZE = SDR_DSIZE
);

  logic             RD_CMD;
  logic             BST_CMD;
  logic [DSIZE-1:0] DQIN;
  logic [DSIZE-1:0] DATAOUT;
  logic             RD_VALID;
  logic             RD_FIRST;
  logic             RD_LAST;
  logic             BUSY;

  // Command path / pad side: issues commands, presents DQ, consumes read data
  modport master (
    output RD_CMD,
    output BST_CMD,
    output DQIN,
    input  DATAOUT,
    input  RD_VALID,
    input  RD_FIRST,
    input  RD_LAST,
    input  BUSY
  );

  // Read data path side
  modport slave (
    input  RD_CMD,
    input  BST_CMD,
    input  DQIN,
    output DATAOUT,
    output RD_VALID,
    output RD_FIRST,
    output RD_LAST,
    output BUSY
  );

endinterface

// File: rtl/sdr_rd_delay.sv
// L-deep shift register carrying {start, stop} events across the CAS latency.
// Stage DEPTH-1 is the event that takes effect on the next clock edge.
module sdr_rd_delay
  import sdr_read_path_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    clr_n,
  input  rd_evt_t din,
  output rd_evt_t taps [DEPTH]
);

  rd_evt_t pipe [DEPTH];

  // Shift events one stage per clock; synchronous clear empties the pipe
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Expose every stage so the framing logic can look one slot ahead
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      taps[i] = pipe[i];
    end
  end

endmodule

// File: rtl/sdr_read_path.sv
// SDRAM read data path: tracks READ / BURST TERMINATE commands through the
// CAS latency, captures returning DQ words and frames them for the host.
module sdr_read_path
  import sdr_read_path_pkg::*;
#(
  parameter int DSIZE     = SDR_DSIZE,
  parameter int CAS_LAT   = SDR_CAS_LAT,
  parameter int BURST_LEN = SDR_BURST_LEN,
  parameter int IN_REG    = SDR_IN_REG
) (
  input  logic           CLK,
  input  logic           RESET_N,
  sdr_read_path_if.slave bus
);

  localparam int L  = rd_latency(CAS_LAT, IN_REG);
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  rd_evt_t          evt_in;
  rd_evt_t          taps [L];
  logic             start_pending;
  logic             start_shift;
  logic             start_em;
  logic             stop_em;
  logic             next_evt;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             active;
  logic             active_next;
  logic             valid_next;
  logic             first_next;
  logic             last_next;
  logic             busy_next;

  logic [DSIZE-1:0] dq_cap;
  logic [DSIZE-1:0] data_r;
  logic             valid_r;
  logic             first_r;
  logic             last_r;
  logic             busy_r;

  sdr_rd_delay #(
    .DEPTH (L)
  ) u_delay (
    .clk   (CLK),
    .clr_n (RESET_N),
    .din   (evt_in),
    .taps  (taps)
  );

  // Pipe entry: READ always wins; a terminate only enters when there is a burst to cut short
  always_comb begin
    start_pending = 1'b0;
    start_shift   = 1'b0;
    for (int i = 0; i < L; i++) begin
      start_pending = start_pending | taps[i].start;
    end
    for (int i = 0; i < L - 1; i++) begin
      start_shift = start_shift | taps[i].start;
    end
    evt_in.start = bus.RD_CMD;
    evt_in.stop  = bus.BST_CMD & ~bus.RD_CMD & (active | start_pending);
  end

  // Burst framing: load on an emerging start, count down while active, close early on a following event
  always_comb begin
    start_em    = taps[L-1].start;
    stop_em     = taps[L-1].stop;
    next_evt    = taps[L-2].start | taps[L-2].stop;
    valid_next  = 1'b0;
    first_next  = 1'b0;
    cnt_next    = cnt;
    if (start_em) begin
      valid_next = 1'b1;
      first_next = 1'b1;
      cnt_next   = CNT_LOAD;
    end else if (active && !stop_em) begin
      valid_next = 1'b1;
      cnt_next   = cnt - CNT_ONE;
    end else begin
      cnt_next   = CNT_ZERO;
    end
    last_next   = valid_next & ((cnt_next == CNT_ZERO) | next_evt);
    active_next = valid_next & ~last_next;
    busy_next   = valid_next | bus.RD_CMD | start_shift;
  end

  // Optional pad-side capture stage for DQ
  generate
    if (IN_REG != 0) begin : g_in_reg
      logic [DSIZE-1:0] dq_q;

      // Sample DQ every clock regardless of read activity
      always_ff @(posedge CLK) begin
        if (!RESET_N) begin
          dq_q <= '0;
        end else begin
          dq_q <= bus.DQIN;
        end
      end

      assign dq_cap = dq_q;
    end else begin : g_no_in_reg
      assign dq_cap = bus.DQIN;
    end
  endgenerate

  // Registered burst state and host-facing outputs; DATAOUT holds between valid words
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt     <= CNT_ZERO;
      active  <= 1'b0;
      valid_r <= 1'b0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      data_r  <= '0;
    end else begin
      cnt     <= cnt_next;
      active  <= active_next;
      valid_r <= valid_next;
      first_r <= first_next;
      last_r  <= last_next;
      busy_r  <= busy_next;
      if (valid_next) begin
        data_r <= dq_cap;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign bus.DATAOUT  = data_r;
  assign bus.RD_VALID = valid_r;
  assign bus.RD_FIRST = first_r;
  assign bus.RD_LAST  = last_r;
  assign bus.BUSY     = busy_r;

endmodule

// File: tb/tb_sdr_read_path.sv
// Directed bench for sdr_read_path: edge-by-edge vectors with hand-computed
// framing masks on a CAS3/IN_REG1/BL8 instance, plus a latency/count sweep
// over all legal CAS_LAT x IN_REG x BURST_LEN combinations.
module tb_sdr_read_path;
  import sdr_read_path_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic [31:0] hold = 32'h0;
  logic sw_rd = 1'b0;
  logic sw_on = 1'b0;
  int   rd_edge = 0;

  always #5 clk = ~clk;

  // Edge counter used by the sweep monitors
  always @(posedge clk) cyc <= cyc + 1;

  sdr_read_path_if #(.DSIZE(32)) mif ();

  sdr_read_path #(
    .DSIZE(32), .CAS_LAT(3), .BURST_LEN(8), .IN_REG(1)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (mif)
  );

  // Sweep instances: every legal configuration, all fed the same single READ
  wire [31:0] sw_first [16];
  wire [31:0] sw_words [16];
  wire [31:0] sw_bad   [16];

  for (genvar c = 0; c < 2; c++) begin : g_cas
    for (genvar r = 0; r < 2; r++) begin : g_reg
      for (genvar b = 0; b < 4; b++) begin : g_bl
        localparam int BL  = 1 << b;
        localparam int IDX = c * 8 + r * 4 + b;
        int first_e = -1;
        int nwords  = 0;
        int flbad   = 0;

        sdr_read_path_if #(.DSIZE(32)) sif ();
        assign sif.RD_CMD  = sw_rd;
        assign sif.BST_CMD = 1'b0;
        assign sif.DQIN    = 32'h0;

        sdr_read_path #(
          .DSIZE(32), .CAS_LAT(2 + c), .BURST_LEN(BL), .IN_REG(r)
        ) u_dut (
          .CLK     (clk),
          .RESET_N (rst_n),
          .bus     (sif)
        );

        // Record arrival of the first word, word count and framing errors
        always @(negedge clk) begin
          if (sw_on && sif.RD_VALID) begin
            if (nwords == 0) first_e <= cyc;
            nwords <= nwords + 1;
            if ((sif.RD_FIRST != (nwords == 0)) || (sif.RD_LAST != (nwords == BL - 1)))
              flbad <= flbad + 1;
          end
        end

        assign sw_first[IDX] = first_e;
        assign sw_words[IDX] = nwords;
        assign sw_bad[IDX]   = flbad;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic [31:0] bst;
    logic [31:0] rst;
    logic [31:0] valid;
    logic [31:0] first;
    logic [31:0] last;
    logic [31:0] busy;
  } vec_t;

  vec_t vecs [7];

  // Drive one vector for 24 edges. DQ words are tagged 0x100+n where n is the
  // edge at which that word would land on DATAOUT (sampled one edge earlier
  // through the pad register).
  task automatic run_case(input vec_t v);
    for (int e = 0; e < 24; e++) begin
      mif.RD_CMD  = v.rd[e];
      mif.BST_CMD = v.bst[e];
      rst_n       = ~v.rst[e];
      mif.DQIN    = 32'h100 + 32'(e) + 32'd1;
      @(posedge clk);
      @(negedge clk);
      if (v.rst[e]) hold = 32'h0;
      else if (v.valid[e]) hold = 32'h100 + 32'(e);
      check_eq($sformatf("%s.e%0d.valid", v.name, e), {31'h0, mif.RD_VALID}, {31'h0, v.valid[e]});
      check_eq($sformatf("%s.e%0d.first", v.name, e), {31'h0, mif.RD_FIRST}, {31'h0, v.first[e]});
      check_eq($sformatf("%s.e%0d.last", v.name, e), {31'h0, mif.RD_LAST}, {31'h0, v.last[e]});
      check_eq($sformatf("%s.e%0d.busy", v.name, e), {31'h0, mif.BUSY}, {31'h0, v.busy[e]});
      check_eq($sformatf("%s.e%0d.data", v.name, e), mif.DATAOUT, hold);
    end
    mif.RD_CMD  = 1'b0;
    mif.BST_CMD = 1'b0;
    rst_n       = 1'b1;
  endtask

  initial begin
    //              name       rd            bst           rst           valid         first         last          busy
    vecs[0] = '{"single",  32'h00000001, 32'h00000000, 32'h00000000, 32'h00000FF0, 32'h00000010, 32'h00000800, 32'h00000FFF};
    vecs[1] = '{"b2b",     32'h00000101, 32'h00000000, 32'h00000000, 32'h000FFFF0, 32'h00001010, 32'h00080800, 32'h000FFFFF};
    vecs[2] = '{"intr",    32'h00000011, 32'h00000000, 32'h00000000, 32'h0000FFF0, 32'h00000110, 32'h00008080, 32'h0000FFFF};
    vecs[3] = '{"bst",     32'h00000001, 32'h00000004, 32'h00000000, 32'h00000030, 32'h00000010, 32'h00000020, 32'h0000003F};
    vecs[4] = '{"bst_idle",32'h00000000, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[5] = '{"rd_bst",  32'h00000001, 32'h00000001, 32'h00000000, 32'h00000FF0, 32'h00000010, 32'h00000800, 32'h00000FFF};
    vecs[6] = '{"rst_mid", 32'h00000001, 32'h00000000, 32'h00000040, 32'h00000030, 32'h00000010, 32'h00000000, 32'h0000003F};

    mif.RD_CMD  = 1'b0;
    mif.BST_CMD = 1'b0;
    mif.DQIN    = 32'h0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst.valid", {31'h0, mif.RD_VALID}, 32'h0);
    check_eq("rst.first", {31'h0, mif.RD_FIRST}, 32'h0);
    check_eq("rst.last",  {31'h0, mif.RD_LAST},  32'h0);
    check_eq("rst.busy",  {31'h0, mif.BUSY},     32'h0);
    check_eq("rst.data",  mif.DATAOUT,           32'h0);
    hold  = 32'h0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_case(vecs[i]);
    end

    // Sweep: one READ into every configuration, then check latency, count, framing
    sw_on = 1'b1;
    sw_rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sw_rd   = 1'b0;
    rd_edge = cyc;
    repeat (30) @(negedge clk);
    sw_on = 1'b0;
    for (int i = 0; i < 16; i++) begin
      int cas;
      int ir;
      int bl;
      cas = 2 + i / 8;
      ir  = (i / 4) % 2;
      bl  = 1 << (i % 4);
      check_eq($sformatf("sweep.c%0d.r%0d.bl%0d.lat", cas, ir, bl), sw_first[i] - 32'(rd_edge), 32'(cas + ir));
      check_eq($sformatf("sweep.c%0d.r%0d.bl%0d.words", cas, ir, bl), sw_words[i], 32'(bl));
      check_eq($sformatf("sweep.c%0d.r%0d.bl%0d.frame", cas, ir, bl), sw_bad[i], 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdr_read_path.md
Name: sdr_read_path

Overview:
- Read-direction data path of the SDRAM controller; the complement of the write data path that drives DQ/DQM.
- Tracks each READ command issued to the SDRAM through the CAS latency, then captures returning DQ words.
- Delivers them to the host port with valid, first and last framing.
- Handles back-to-back reads, read-interrupts-read, and BURST TERMINATE.

Parameters:
- DSIZE, 32, data bus width (from the shared SDRAM params).
- CAS_LAT, 3, SDRAM CAS latency in clocks; legal values 2 or 3.
- BURST_LEN, 8, programmed burst length; legal values 1, 2, 4 or 8.
- IN_REG, 1, extra DQ capture register stage at the pad; legal values 0 or 1.

Ports:
- CLK  input  1  system clock, same clock as command path.
- RESET_N  input  1  synchronous, active-low reset.
- RD_CMD  input  1  pulse: READ command driven to SDRAM this cycle.
- BST_CMD  input  1  pulse: BURST TERMINATE driven to SDRAM this cycle.
- DQIN  input  DSIZE  SDRAM DQ input.
- DATAOUT  output  DSIZE  read data to host.
- RD_VALID  output  1  DATAOUT holds a valid read word.
- RD_FIRST  output  1  first word of a burst.
- RD_LAST  output  1  final word of a burst, whether full or truncated.
- BUSY  output  1  a read is in flight or being delivered.

Behaviour:
- Reset: all outputs and internal state are registered and clear on the first CLK edge with RESET_N=0.
  - DATAOUT=0, RD_VALID=RD_FIRST=RD_LAST=BUSY=0.
  - Delay pipe and burst counter are cleared.
  - Reset mid-burst aborts the burst; no further RD_VALID appears for it.
- Latency: define L = CAS_LAT + IN_REG.
  - RD_CMD sampled at edge k gives word 0 on DATAOUT with RD_VALID=1 after edge k+L.
  - Words 1..BURST_LEN-1 follow on consecutive cycles; there are no gaps.
- Capture: DQIN is sampled each edge (through IN_REG stages) regardless of activity. DATAOUT changes only when RD_VALID is asserted, and otherwise holds its last value.
- Event pipe: RD_CMD and BST_CMD each enter an L-deep shift register.
  - Start event emerging: load burst counter = BURST_LEN-1; assert RD_VALID and RD_FIRST.
  - While counter > 0 and the burst is active: RD_VALID=1 and the counter decrements each cycle.
- RD_LAST: asserted on the word where the counter is 0. It is also asserted one cycle early when the next pipe stage holds a start or stop event, so truncated bursts are always closed.
- Interrupt: RD_CMD during an active burst.
  - The new burst's word 0 appears at its own k'+L and the old burst is discarded from that point.
  - The word before it carries RD_LAST.
  - RD_VALID stays continuous.
- BST_CMD at edge b while a burst is active or pending:
  - The last valid word is the one at edge b+L-1, and it carries RD_LAST.
  - RD_VALID=0 from edge b+L unless a new start arrives.
  - BST_CMD with nothing active or pending is ignored.
- RD_CMD and BST_CMD in the same cycle: RD_CMD wins and BST_CMD is ignored.
- BURST_LEN=1: every word has RD_FIRST=RD_LAST=1.
- BUSY: registered. It is 1 while any pipe stage holds a start, or while the burst is active, and falls the cycle after the final RD_LAST.
- Host back-pressure: none. The host must accept every RD_VALID word.

Decomposition:
- Shared SDRAM params include file: DSIZE; legal CAS latency and burst length encodings; derived L.
- Sub-module sdr_rd_delay: parameterized L-deep, 2-bit-wide shift register {start, stop} with synchronous active-low clear.
- The burst counter and framing logic stay in sdr_read_path.

Test Plan:
- Single read, CAS_LAT=3, IN_REG=1, BURST_LEN=8: RD_CMD at edge 0, DQIN=0x100+cycle → RD_VALID edges 4..11, DATAOUT 0x104..0x10B, RD_FIRST at 4, RD_LAST at 11, BUSY low after 12.
- Back-to-back reads at edges 0 and 8 → RD_VALID continuous 4..19; RD_FIRST at 4,12; RD_LAST at 11,19.
- Interrupt: RD at 0 and 4 → words at 4..7 from burst A with RD_LAST at 7; burst B 8..15, RD_FIRST at 8, RD_LAST at 15.
- Terminate: RD at 0, BST at 2 → RD_VALID only at edges 4,5; RD_LAST at 5. BST with bus idle → no output activity.
- RD_CMD and BST_CMD together at 0 → full 8-word burst. RESET_N low at edge 6 of a burst → all outputs 0 from edge 6; no valid words afterwards.
- Parameter sweep CAS_LAT={2,3} × IN_REG={0,1} × BURST_LEN={1,2,4,8} → first word at k+L, exact count, BURST_LEN=1 gives FIRST=LAST on every word.
